// File: rtl/acc_requant_drain_if.sv
// Bundle of the drain command, config and requantized output stream.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready on the output stream; start is a level sampled when idle.
// Ports: master = PE-array/consumer side, slave = drain block side.
interface acc_requant_drain_if #(
    parameter int NUM_PE      = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5
) ();
    localparam int IDX_WIDTH = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic                          start;
    logic [NUM_PE*ACC_WIDTH-1:0]   acc_vec;
    logic [ACC_WIDTH-1:0]          bias;
    logic [SCALE_WIDTH-1:0]        scale;
    logic [SHIFT_WIDTH-1:0]        shift;
    logic                          relu_en;
    logic                          clear_acc;
    logic                          busy;
    logic                          out_valid;
    logic                          out_ready;
    logic [OUT_WIDTH-1:0]          out_data;
    logic [IDX_WIDTH-1:0]          out_idx;
    logic                          out_last;
    logic                          done;

    modport master (
        output start, acc_vec, bias, scale, shift, relu_en, out_ready,
        input  clear_acc, busy, out_valid, out_data, out_idx, out_last, done
    );

    modport slave (
        input  start, acc_vec, bias, scale, shift, relu_en, out_ready,
        output clear_acc, busy, out_valid, out_data, out_idx, out_last, done
    );
endinterface

// File: rtl/acc_requant_drain.sv
// Snapshots NUM_PE accumulators on start, pulses clear_acc, streams each through bias/scale/round/ReLU/sat to int8.
// Latency: first out_valid 2 cycles after the capture edge, then 1 element/cycle.
// Backpressure: out_ready low with out_valid high freezes stage 1, the output register and the issue index.
// Ports: i_clk, i_rst_n (async active-low), io_bus (slave side of acc_requant_drain_if).
module acc_requant_drain #(
    parameter int NUM_PE      = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    acc_requant_drain_if.slave   io_bus
);
    localparam int IDX_WIDTH  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int CNT_WIDTH  = $clog2(NUM_PE + 1);
    localparam int PROD_WIDTH = ACC_WIDTH + SCALE_WIDTH + 2;

    localparam logic [CNT_WIDTH-1:0] CNT_END  = CNT_WIDTH'(NUM_PE);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_PE - 1);
    // Saturation limits expressed in the width of the rounded product.
    localparam logic signed [PROD_WIDTH:0] SAT_MAX =
        {{(PROD_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [PROD_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    state_t                         r_state;
    logic [NUM_PE*ACC_WIDTH-1:0]    r_acc_vec;
    logic [ACC_WIDTH-1:0]           r_bias;
    logic [SCALE_WIDTH-1:0]         r_scale;
    logic [SHIFT_WIDTH-1:0]         r_shift;
    logic                           r_relu;
    logic [CNT_WIDTH-1:0]           r_iss_cnt;
    logic                           r_s1_vld;
    logic signed [PROD_WIDTH-1:0]   r_s1_prod;
    logic [IDX_WIDTH-1:0]           r_s1_idx;
    logic                           r_clear;
    logic                           r_busy;
    logic                           r_out_vld;
    logic [OUT_WIDTH-1:0]           r_out_dat;
    logic [IDX_WIDTH-1:0]           r_out_idx;
    logic                           r_out_last;
    logic                           r_done;

    logic                           w_adv;
    logic                           w_hs;
    logic [IDX_WIDTH-1:0]           w_iss_idx;
    logic [ACC_WIDTH-1:0]           w_acc;
    logic signed [ACC_WIDTH:0]      w_sum;
    logic signed [PROD_WIDTH-1:0]   w_prod;
    logic signed [PROD_WIDTH:0]     w_rnd;
    logic signed [PROD_WIDTH:0]     w_rsum;
    logic signed [PROD_WIDTH:0]     w_shifted;
    logic [OUT_WIDTH-1:0]           w_out;

    assign w_adv     = !r_out_vld || io_bus.out_ready;
    assign w_hs      = r_out_vld && io_bus.out_ready;
    assign w_iss_idx = r_iss_cnt[IDX_WIDTH-1:0];
    assign w_acc     = r_acc_vec[w_iss_idx*ACC_WIDTH +: ACC_WIDTH];

    // Stage 1 datapath: one extra bit on the sum so bias cannot wrap; the
    // product width covers the full signed x unsigned range exactly.
    assign w_sum  = $signed({w_acc[ACC_WIDTH-1], w_acc}) + $signed({r_bias[ACC_WIDTH-1], r_bias});
    assign w_prod = $signed({{(PROD_WIDTH-ACC_WIDTH-1){w_sum[ACC_WIDTH]}}, w_sum})
                  * $signed({{(PROD_WIDTH-SCALE_WIDTH){1'b0}}, r_scale});

    // Stage 2 datapath: half-LSB (1<<(shift-1), zero when shift==0) added
    // before the arithmetic shift gives round-half-up.
    assign w_rnd     = $signed(({{PROD_WIDTH{1'b0}}, 1'b1} << r_shift) >> 1);
    assign w_rsum    = $signed({r_s1_prod[PROD_WIDTH-1], r_s1_prod}) + w_rnd;
    assign w_shifted = w_rsum >>> r_shift;

    always_comb begin
        w_out = w_shifted[OUT_WIDTH-1:0];
        if (r_relu && w_shifted[PROD_WIDTH]) begin
            w_out = '0;
        end else if (w_shifted > SAT_MAX) begin
            w_out = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_out = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_acc_vec  <= '0;
            r_bias     <= '0;
            r_scale    <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_iss_cnt  <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_idx   <= '0;
            r_clear    <= 1'b0;
            r_busy     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_clear <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_acc_vec <= io_bus.acc_vec;
                        r_bias    <= io_bus.bias;
                        r_scale   <= io_bus.scale;
                        r_shift   <= io_bus.shift;
                        r_relu    <= io_bus.relu_en;
                        r_iss_cnt <= '0;
                        r_s1_vld  <= 1'b0;
                        r_clear   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_adv) begin
                        if (r_iss_cnt < CNT_END) begin
                            r_s1_prod <= w_prod;
                            r_s1_idx  <= w_iss_idx;
                            r_iss_cnt <= r_iss_cnt + 1'b1;
                            r_s1_vld  <= 1'b1;
                        end else begin
                            r_s1_vld  <= 1'b0;
                        end
                        r_out_vld  <= r_s1_vld;
                        r_out_dat  <= w_out;
                        r_out_idx  <= r_s1_idx;
                        r_out_last <= (r_s1_idx == IDX_LAST);
                    end
                    // Only the last element can be in flight here, so the
                    // advance above has already emptied the pipeline.
                    if (w_hs && r_out_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.clear_acc = r_clear;
    assign io_bus.busy      = r_busy;
    assign io_bus.out_valid = r_out_vld;
    assign io_bus.out_data  = r_out_dat;
    assign io_bus.out_idx   = r_out_idx;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.done      = r_done;
endmodule

// File: tb/tb_acc_requant_drain.sv
// Testbench for acc_requant_drain: directed spec scenarios plus randomized drains vs an arithmetic model.
module tb_acc_requant_drain;
    localparam int NUM_PE      = 4;
    localparam int ACC_WIDTH   = 32;
    localparam int OUT_WIDTH   = 8;
    localparam int SCALE_WIDTH = 16;
    localparam int SHIFT_WIDTH = 5;
    localparam int BUDGET      = 200;
    localparam int OMAX        = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int OMIN        = -(1 << (OUT_WIDTH - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    acc_requant_drain_if #(
        .NUM_PE(NUM_PE), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .SCALE_WIDTH(SCALE_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
    ) bus ();

    acc_requant_drain #(
        .NUM_PE(NUM_PE), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .SCALE_WIDTH(SCALE_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int stim_acc[NUM_PE];
    int obs_data[$];
    int obs_idx[$];
    int obs_last[$];
    int first_valid_cyc, done_cyc, clear_cnt, done_cnt, hold_err, busy_err, late_valid, idx1_cycles;
    bit timed_out;

    // Reference: plain integer arithmetic on the rules (add, multiply, round half up, relu, clamp).
    function automatic int model_out(int a, int b, int sc, int sh, bit relu);
        longint p;
        longint r;
        p = (longint'(a) + longint'(b)) * longint'(sc);
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
        r = p >>> sh;
        if (relu && r < 0) r = 0;
        if (r > OMAX) r = OMAX;
        if (r < OMIN) r = OMIN;
        return int'(r);
    endfunction

    function automatic int got_data(int i);
        return (i < obs_data.size()) ? obs_data[i] : 9999;
    endfunction
    function automatic int got_idx(int i);
        return (i < obs_idx.size()) ? obs_idx[i] : 9999;
    endfunction
    function automatic int got_last(int i);
        return (i < obs_last.size()) ? obs_last[i] : 9999;
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < NUM_PE; i++) bus.acc_vec[i*ACC_WIDTH +: ACC_WIDTH] = $urandom;
        bus.bias    = $urandom;
        bus.scale   = SCALE_WIDTH'($urandom);
        bus.shift   = SHIFT_WIDTH'($urandom);
        bus.relu_en = 1'($urandom);
    endtask

    // Launches one drain from stim_acc and records what the DUT emits; called at #1 after a posedge.
    task automatic run_drain(input int bias_in, input int scale_in, input int shift_in, input bit relu_in,
                             input int stall_idx, input int stall_len, input bit rnd_ready, input bit mid_start);
        int  c;
        int  post;
        int  stall_left;
        bit  done_seen;
        bit  prev_stall;
        int  pd, pi, pl;
        obs_data.delete(); obs_idx.delete(); obs_last.delete();
        first_valid_cyc = -1; done_cyc = -1; clear_cnt = 0; done_cnt = 0;
        hold_err = 0; busy_err = 0; late_valid = 0; idx1_cycles = 0; timed_out = 1'b0;
        for (int i = 0; i < NUM_PE; i++) bus.acc_vec[i*ACC_WIDTH +: ACC_WIDTH] = stim_acc[i];
        bus.bias      = bias_in;
        bus.scale     = SCALE_WIDTH'(scale_in);
        bus.shift     = SHIFT_WIDTH'(shift_in);
        bus.relu_en   = relu_in;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble_inputs();
        c = 0; post = 0; stall_left = stall_len; done_seen = 1'b0; prev_stall = 1'b0;
        pd = 0; pi = 0; pl = 0;
        while (post < 4) begin
            if (c >= BUDGET) begin
                timed_out = 1'b1;
                break;
            end
            if (bus.out_valid && stall_left > 0 && int'(bus.out_idx) == stall_idx) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else if (rnd_ready) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
            bus.start = mid_start && (c == 3);
            if (bus.start) scramble_inputs();
            if (bus.clear_acc) clear_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (!done_seen) done_cyc = c;
                done_seen = 1'b1;
            end
            if (done_seen ? bus.busy : !bus.busy) busy_err++;
            if (prev_stall && (!bus.out_valid || int'($signed(bus.out_data)) != pd ||
                               int'(bus.out_idx) != pi || int'(bus.out_last) != pl)) hold_err++;
            if (bus.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = c;
                if (done_seen) late_valid++;
                if (int'(bus.out_idx) == 1) idx1_cycles++;
                if (bus.out_ready) begin
                    obs_data.push_back(int'($signed(bus.out_data)));
                    obs_idx.push_back(int'(bus.out_idx));
                    obs_last.push_back(int'(bus.out_last));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            pd = int'($signed(bus.out_data));
            pi = int'(bus.out_idx);
            pl = int'(bus.out_last);
            if (done_seen) post++;
            @(posedge clk); #1;
            c++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({bus.clear_acc, bus.busy, bus.out_valid, bus.out_last, bus.done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.clear_acc, bus.busy, bus.out_valid, bus.out_last, bus.done});
        end
        n_checks++;
        if (bus.out_data !== '0 || bus.out_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data %0d idx %0d expected 0 0", bus.out_data, bus.out_idx);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy %b valid %b expected 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_passthrough();
        int exp_d[NUM_PE];
        exp_d    = '{100, -100, 127, 5};
        stim_acc = '{100, -100, 1000, 5};
        run_drain(0, 1, 0, 1'b0, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (timed_out || obs_data.size() != NUM_PE) begin
            n_fail++;
            $display("FAIL pt_count: got %0d elements (timeout %0d) expected %0d", obs_data.size(), timed_out, NUM_PE);
        end
        for (int i = 0; i < NUM_PE; i++) begin
            n_checks++;
            if (got_data(i) != exp_d[i] || got_idx(i) != i || got_last(i) != int'(i == NUM_PE - 1)) begin
                n_fail++;
                $display("FAIL pt_elem%0d: got data %0d idx %0d last %0d expected %0d %0d %0d",
                         i, got_data(i), got_idx(i), got_last(i), exp_d[i], i, int'(i == NUM_PE - 1));
            end
        end
        n_checks++;
        if (first_valid_cyc != 2) begin
            n_fail++;
            $display("FAIL pt_first_valid: got cycle %0d expected 2", first_valid_cyc);
        end
        n_checks++;
        if (done_cyc != NUM_PE + 2 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL pt_done: got cycle %0d count %0d expected %0d 1", done_cyc, done_cnt, NUM_PE + 2);
        end
        n_checks++;
        if (clear_cnt != 1) begin
            n_fail++;
            $display("FAIL pt_clear: got %0d pulses expected 1", clear_cnt);
        end
        n_checks++;
        if (busy_err != 0 || late_valid != 0) begin
            n_fail++;
            $display("FAIL pt_busy: got %0d busy errors %0d late valids expected 0 0", busy_err, late_valid);
        end
    endtask

    task automatic test_round_relu();
        int exp_n[NUM_PE];
        int exp_r[NUM_PE];
        exp_n    = '{2, -1, -2, -50};
        exp_r    = '{2, 0, 0, 0};
        stim_acc = '{3, -3, -5, -100};
        for (int pass = 0; pass < 2; pass++) begin
            run_drain(0, 1, 1, pass[0], -1, 0, 1'b0, 1'b0);
            n_checks++;
            if (timed_out || obs_data.size() != NUM_PE) begin
                n_fail++;
                $display("FAIL rnd_count relu=%0d: got %0d expected %0d", pass, obs_data.size(), NUM_PE);
            end
            for (int i = 0; i < NUM_PE; i++) begin
                n_checks++;
                if (got_data(i) != (pass == 1 ? exp_r[i] : exp_n[i])) begin
                    n_fail++;
                    $display("FAIL rnd_elem%0d relu=%0d: got %0d expected %0d",
                             i, pass, got_data(i), (pass == 1 ? exp_r[i] : exp_n[i]));
                end
            end
        end
    endtask

    task automatic test_scale_sat();
        int exp_d[NUM_PE];
        exp_d    = '{127, -128, 8, -7};
        stim_acc = '{int'(32'h7FFF_FFFF), int'(32'h8000_0000), 10, -10};
        run_drain(1, 3, 2, 1'b0, -1, 0, 1'b0, 1'b0);
        for (int i = 0; i < NUM_PE; i++) begin
            n_checks++;
            if (got_data(i) != exp_d[i] || got_idx(i) != i) begin
                n_fail++;
                $display("FAIL sat_elem%0d: got data %0d idx %0d expected %0d %0d",
                         i, got_data(i), got_idx(i), exp_d[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_d[NUM_PE];
        exp_d    = '{100, -100, 127, 5};
        stim_acc = '{100, -100, 1000, 5};
        run_drain(0, 1, 0, 1'b0, 1, 3, 1'b0, 1'b0);
        n_checks++;
        if (timed_out || obs_data.size() != NUM_PE) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected %0d", obs_data.size(), NUM_PE);
        end
        for (int i = 0; i < NUM_PE; i++) begin
            n_checks++;
            if (got_data(i) != exp_d[i] || got_idx(i) != i) begin
                n_fail++;
                $display("FAIL bp_elem%0d: got data %0d idx %0d expected %0d %0d",
                         i, got_data(i), got_idx(i), exp_d[i], i);
            end
        end
        n_checks++;
        if (idx1_cycles != 4 || hold_err != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d cycles %0d unstable expected 4 0", idx1_cycles, hold_err);
        end
        n_checks++;
        if (done_cyc != NUM_PE + 5 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_done: got cycle %0d count %0d expected %0d 1", done_cyc, done_cnt, NUM_PE + 5);
        end
    endtask

    task automatic test_start_busy();
        int exp_d[NUM_PE];
        exp_d    = '{2, -1, -2, -50};
        stim_acc = '{3, -3, -5, -100};
        run_drain(0, 1, 1, 1'b0, -1, 0, 1'b0, 1'b1);
        for (int i = 0; i < NUM_PE; i++) begin
            n_checks++;
            if (got_data(i) != exp_d[i]) begin
                n_fail++;
                $display("FAIL sb_elem%0d: got %0d expected %0d", i, got_data(i), exp_d[i]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || clear_cnt != 1 || obs_data.size() != NUM_PE || late_valid != 0) begin
            n_fail++;
            $display("FAIL sb_once: got done %0d clear %0d elems %0d late %0d expected 1 1 %0d 0",
                     done_cnt, clear_cnt, obs_data.size(), late_valid, NUM_PE);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        int stray;
        int exp_d[NUM_PE];
        exp_d = '{100, -100, 127, 5};
        for (int i = 0; i < NUM_PE; i++) bus.acc_vec[i*ACC_WIDTH +: ACC_WIDTH] = exp_d[i] == 127 ? 1000 : exp_d[i];
        bus.bias = '0; bus.scale = SCALE_WIDTH'(1); bus.shift = '0; bus.relu_en = 1'b0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 0;
        while (!(bus.out_valid && bus.out_idx == 1) && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (c >= 20) begin
            n_fail++;
            $display("FAIL rm_reach_elem1: got timeout expected element 1 valid");
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.clear_acc, bus.busy, bus.out_valid, bus.out_last, bus.done} !== 5'b0 ||
            bus.out_data !== '0 || bus.out_idx !== '0) begin
            n_fail++;
            $display("FAIL rm_async_clear: got flags %b data %0d idx %0d expected 00000 0 0",
                     {bus.clear_acc, bus.busy, bus.out_valid, bus.out_last, bus.done}, bus.out_data, bus.out_idx);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.done || bus.busy) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rm_quiet: got %0d active cycles expected 0", stray);
        end
        stim_acc = '{100, -100, 1000, 5};
        run_drain(0, 1, 0, 1'b0, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (obs_data.size() != NUM_PE || done_cnt != 1 || first_valid_cyc != 2) begin
            n_fail++;
            $display("FAIL rm_redrain: got elems %0d done %0d first %0d expected %0d 1 2",
                     obs_data.size(), done_cnt, first_valid_cyc, NUM_PE);
        end
        for (int i = 0; i < NUM_PE; i++) begin
            n_checks++;
            if (got_data(i) != exp_d[i] || got_idx(i) != i) begin
                n_fail++;
                $display("FAIL rm_elem%0d: got data %0d idx %0d expected %0d %0d",
                         i, got_data(i), got_idx(i), exp_d[i], i);
            end
        end
    endtask

    task automatic test_random();
        int b, sc, sh;
        bit rl;
        int e;
        for (int d = 0; d < 10; d++) begin
            for (int i = 0; i < NUM_PE; i++)
                stim_acc[i] = (d % 2 == 0) ? int'($urandom) : $urandom_range(0, 4000) - 2000;
            b  = (d % 3 == 0) ? int'($urandom) : $urandom_range(0, 200) - 100;
            sc = (d % 2 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300);
            sh = (d % 2 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 12);
            rl = 1'($urandom);
            run_drain(b, sc, sh, rl, -1, 0, 1'b1, 1'b0);
            n_checks++;
            if (timed_out || obs_data.size() != NUM_PE || done_cnt != 1 || hold_err != 0 || busy_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_flow: got elems %0d done %0d hold %0d busy %0d to %0d expected %0d 1 0 0 0",
                         d, obs_data.size(), done_cnt, hold_err, busy_err, timed_out, NUM_PE);
            end
            for (int i = 0; i < NUM_PE; i++) begin
                e = model_out(stim_acc[i], b, sc, sh, rl);
                n_checks++;
                if (got_data(i) != e || got_idx(i) != i || got_last(i) != int'(i == NUM_PE - 1)) begin
                    n_fail++;
                    $display("FAIL rand%0d_elem%0d: got data %0d idx %0d expected %0d %0d (acc %0d bias %0d scale %0d shift %0d relu %0d)",
                             d, i, got_data(i), got_idx(i), e, i, stim_acc[i], b, sc, sh, rl);
                end
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.acc_vec   = '0;
        bus.bias      = '0;
        bus.scale     = '0;
        bus.shift     = '0;
        bus.relu_en   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_passthrough();
        test_round_relu();
        test_scale_sat();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
